// File: rtl/nmr_sched_pkg.sv
// Shared types and constants for the NMR multi-scan scheduler.
package nmr_sched_pkg;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_LAUNCH   = 5'b00010,
    ST_WAIT_END = 5'b00100,
    ST_REP_WAIT = 5'b01000,
    ST_FINISH   = 5'b10000
  } sched_state_e;

  localparam int unsigned ACK_TIMEOUT_DEF = 15;
  localparam logic        PHASE_CYC_IDLE  = 1'b1;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/nmr_sched_delay_cnt.sv
// Loadable saturating down-counter with zero flag; serves both the
// repetition delay and the pulse-program ack timeout.
module nmr_sched_delay_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero_c
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/nmr_scan_scheduler.sv
// Multi-scan sequencer driving the pulse-program START/PHASE_CYC inputs:
// back-to-back scans, repetition delay, phase cycling, abort and ack timeout.
module nmr_scan_scheduler
  import nmr_sched_pkg::*;
#(
  parameter int unsigned SCAN_CNT_WIDTH  = 16,
  parameter int unsigned REP_DELAY_WIDTH = 32,
  parameter int unsigned ACK_TIMEOUT     = ACK_TIMEOUT_DEF
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       RUN,
  input  logic                       ABORT,
  input  logic [SCAN_CNT_WIDTH-1:0]  NUM_SCANS,
  input  logic [REP_DELAY_WIDTH-1:0] REP_DELAY,
  input  logic                       PHASE_CYC_EN,
  input  logic                       PP_FSMSTAT,
  output logic                       PP_START,
  output logic                       PHASE_CYC,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       ERR,
  output logic [SCAN_CNT_WIDTH-1:0]  SCAN_IDX
);

  localparam int unsigned       ACK_W    = cnt_width(ACK_TIMEOUT);
  localparam logic [ACK_W-1:0]  ACK_LOAD = ACK_W'(ACK_TIMEOUT - 1);

  sched_state_e                r_state;
  logic                        r_pp_start;
  logic                        r_phase_cyc;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_err;
  logic                        r_abort_pend;
  logic                        r_phase_en;
  logic [SCAN_CNT_WIDTH-1:0]   r_scan_idx;
  logic [SCAN_CNT_WIDTH-1:0]   r_num_scans;
  logic [REP_DELAY_WIDTH-1:0]  r_rep_delay;

  logic                        w_ack_load;
  logic                        w_ack_en;
  logic                        w_ack_zero;
  logic                        w_rep_load;
  logic                        w_rep_en;
  logic                        w_rep_zero;
  logic                        w_last;
  logic [SCAN_CNT_WIDTH-1:0]   w_idx_next;

  // Counter controls must act on the same edge as the state transition.
  always_comb begin
    w_ack_load = 1'b0;
    w_ack_en   = 1'b0;
    w_rep_load = 1'b0;
    w_rep_en   = 1'b0;
    w_idx_next = r_scan_idx + SCAN_CNT_WIDTH'(1);
    w_last     = (w_idx_next == r_num_scans) || r_abort_pend || ABORT;
    case (r_state)
      ST_LAUNCH: begin
        if (!PP_FSMSTAT) begin
          w_ack_load = !r_pp_start;
          w_ack_en   = r_pp_start;
        end
      end
      ST_WAIT_END: w_rep_load = !PP_FSMSTAT && !w_last;
      ST_REP_WAIT: begin
        w_rep_en   = 1'b1;
        w_ack_load = w_rep_zero && !ABORT;
      end
      default: ;
    endcase
  end

  nmr_sched_delay_cnt #(.WIDTH(REP_DELAY_WIDTH)) u_rep_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_load     (w_rep_load),
    .i_en       (w_rep_en),
    .i_load_val (r_rep_delay),
    .o_zero_c   (w_rep_zero)
  );

  // Loaded as PP_START rises, so it counts the cycles START has been high.
  nmr_sched_delay_cnt #(.WIDTH(ACK_W)) u_ack_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_load     (w_ack_load),
    .i_en       (w_ack_en),
    .i_load_val (ACK_LOAD),
    .o_zero_c   (w_ack_zero)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_pp_start   <= 1'b0;
      r_phase_cyc  <= PHASE_CYC_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_phase_en   <= 1'b0;
      r_scan_idx   <= '0;
      r_num_scans  <= '0;
      r_rep_delay  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done       <= 1'b0;
          r_abort_pend <= 1'b0;
          if (RUN) begin
            r_num_scans <= NUM_SCANS;
            r_rep_delay <= REP_DELAY;
            r_phase_en  <= PHASE_CYC_EN;
            r_err       <= 1'b0;
            r_scan_idx  <= '0;
            r_phase_cyc <= PHASE_CYC_IDLE;
            r_busy      <= 1'b1;
            r_state     <= (NUM_SCANS == '0) ? ST_FINISH : ST_LAUNCH;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          if (ABORT) r_abort_pend <= 1'b1;
          if (PP_FSMSTAT) begin
            r_pp_start <= 1'b0;
            r_state    <= ST_WAIT_END;
          end else if (r_pp_start && w_ack_zero) begin
            r_pp_start <= 1'b0;
            r_err      <= 1'b1;
            r_state    <= ST_FINISH;
          end else begin
            r_pp_start <= 1'b1;
          end
        end
        ST_WAIT_END: begin
          if (ABORT) r_abort_pend <= 1'b1;
          if (!PP_FSMSTAT) begin
            r_scan_idx  <= w_idx_next;
            r_phase_cyc <= r_phase_en ? ~w_idx_next[0] : PHASE_CYC_IDLE;
            r_state     <= w_last ? ST_FINISH : ST_REP_WAIT;
          end
        end
        ST_REP_WAIT: begin
          // Raising START on the leaving edge keeps REP_DELAY=0 at a 1-cycle gap.
          if (ABORT) begin
            r_state <= ST_FINISH;
          end else if (w_rep_zero) begin
            r_pp_start <= 1'b1;
            r_state    <= ST_LAUNCH;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign PP_START  = r_pp_start;
  assign PHASE_CYC = r_phase_cyc;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERR       = r_err;
  assign SCAN_IDX  = r_scan_idx;

endmodule

// File: tb/tb_nmr_scan_scheduler.sv
// Directed bench for nmr_scan_scheduler with a behavioural pulse-program model.
module tb_nmr_scan_scheduler;

  localparam int PP_LEN = 8;

  logic        CLK;
  logic        RESET;
  logic        RUN;
  logic        ABORT;
  logic [15:0] NUM_SCANS;
  logic [31:0] REP_DELAY;
  logic        PHASE_CYC_EN;
  logic        PP_FSMSTAT;
  logic        PP_START;
  logic        PHASE_CYC;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] SCAN_IDX;

  int checks   = 0;
  int failures = 0;

  nmr_scan_scheduler dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .RUN          (RUN),
    .ABORT        (ABORT),
    .NUM_SCANS    (NUM_SCANS),
    .REP_DELAY    (REP_DELAY),
    .PHASE_CYC_EN (PHASE_CYC_EN),
    .PP_FSMSTAT   (PP_FSMSTAT),
    .PP_START     (PP_START),
    .PHASE_CYC    (PHASE_CYC),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERR          (ERR),
    .SCAN_IDX     (SCAN_IDX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse program: START seen -> arm -> busy for PP_LEN cycles -> back to S0.
  logic       pp_model_en;
  logic       pp_busy;
  logic [1:0] pp_st;
  int         pp_cnt;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pp_st   <= 2'd0;
      pp_busy <= 1'b0;
      pp_cnt  <= 0;
    end else if (pp_model_en) begin
      case (pp_st)
        2'd0: if (PP_START) pp_st <= 2'd1;
        2'd1: begin pp_busy <= 1'b1; pp_cnt <= PP_LEN - 1; pp_st <= 2'd2; end
        default: begin
          if (pp_cnt == 0) begin pp_busy <= 1'b0; pp_st <= 2'd0; end
          else pp_cnt <= pp_cnt - 1;
        end
      endcase
    end
  end

  assign PP_FSMSTAT = pp_model_en & pp_busy;

  // Monitor: START pulse lengths, phase at rise, gap from FSMSTAT-fall sample edge.
  int   cyc = 0;
  int   n_starts = 0;
  int   n_done = 0;
  int   fall_n = 0;
  int   rise_n [64];
  int   len_n  [64];
  int   gap_n  [64];
  logic ph_n   [64];
  logic prev_start = 1'b0;
  logic prev_stat  = 1'b0;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (PP_START && !prev_start && n_starts < 64) begin
      rise_n[n_starts] = cyc;
      ph_n[n_starts]   = PHASE_CYC;
      gap_n[n_starts]  = cyc - (fall_n + 1);
      len_n[n_starts]  = 0;
      n_starts = n_starts + 1;
    end
    if (!PP_START && prev_start && n_starts > 0)
      len_n[n_starts-1] = cyc - rise_n[n_starts-1];
    if (!PP_FSMSTAT && prev_stat) fall_n = cyc;
    if (DONE) n_done = n_done + 1;
    prev_start = PP_START;
    prev_stat  = PP_FSMSTAT;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (DONE !== 1'b1 && k < 1000) begin tick(); k++; end
    checks++;
    if (DONE !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout: DONE=%b after %0d cycles, want 1", name, DONE, k);
    end
  endtask

  task automatic start_run(input logic [15:0] n, input logic [31:0] d, input logic pe);
    NUM_SCANS    = n;
    REP_DELAY    = d;
    PHASE_CYC_EN = pe;
    RUN = 1'b1;
    tick();
    RUN = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(); tick();
    checks++; if (PP_START !== 1'b0) begin failures++; $display("FAIL rst_pp_start: got %b want 0", PP_START); end
    checks++; if (PHASE_CYC !== 1'b1) begin failures++; $display("FAIL rst_phase: got %b want 1", PHASE_CYC); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL rst_done_err: got %b%b want 00", DONE, ERR); end
    checks++; if (SCAN_IDX !== 16'd0) begin failures++; $display("FAIL rst_scan_idx: got %0d want 0", SCAN_IDX); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_four_scans();
    int b, d0;
    b  = n_starts;
    d0 = n_done;
    start_run(16'd4, 32'd10, 1'b1);
    checks++; if (BUSY !== 1'b1 || PP_START !== 1'b0) begin failures++; $display("FAIL run_entry: busy=%b start=%b want 1,0", BUSY, PP_START); end
    tick();
    checks++; if (PP_START !== 1'b1) begin failures++; $display("FAIL run_start_latency: got %b want 1", PP_START); end
    wait_done("four");
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL four_busy_at_done: got %b want 1", BUSY); end
    checks++; if (SCAN_IDX !== 16'd4) begin failures++; $display("FAIL four_scan_idx: got %0d want 4", SCAN_IDX); end
    tick();
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL four_after_done: busy=%b done=%b want 0,0", BUSY, DONE); end
    checks++; if (n_starts - b !== 4) begin failures++; $display("FAIL four_start_count: got %0d want 4", n_starts - b); end
    checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL four_done_count: got %0d want 1", n_done - d0); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL four_err: got %b want 0", ERR); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (len_n[b+i] !== 3) begin failures++; $display("FAIL four_start_len%0d: got %0d want 3", i, len_n[b+i]); end
      checks++; if (ph_n[b+i] !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL four_phase%0d: got %b want %b", i, ph_n[b+i], (i % 2 == 0)); end
      if (i > 0) begin
        checks++; if (gap_n[b+i] !== 11) begin failures++; $display("FAIL four_gap%0d: got %0d want 11", i, gap_n[b+i]); end
      end
    end
  endtask

  task automatic test_zero_scans();
    int b;
    b = n_starts;
    start_run(16'd0, 32'd5, 1'b1);
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL zero_busy: got %b want 1", BUSY); end
    tick();
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL zero_done: got %b want 1", DONE); end
    checks++; if (SCAN_IDX !== 16'd0) begin failures++; $display("FAIL zero_scan_idx: got %0d want 0", SCAN_IDX); end
    tick();
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL zero_end: busy=%b done=%b want 0,0", BUSY, DONE); end
    checks++; if (n_starts !== b) begin failures++; $display("FAIL zero_no_start: got %0d want 0", n_starts - b); end
  endtask

  task automatic test_ack_timeout();
    int b;
    b = n_starts;
    pp_model_en = 1'b0;
    start_run(16'd3, 32'd2, 1'b1);
    wait_done("timeout");
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL timeout_err: got %b want 1", ERR); end
    checks++; if (SCAN_IDX !== 16'd0) begin failures++; $display("FAIL timeout_scan_idx: got %0d want 0", SCAN_IDX); end
    checks++; if (n_starts - b !== 1) begin failures++; $display("FAIL timeout_start_count: got %0d want 1", n_starts - b); end
    checks++; if (len_n[b] !== 15) begin failures++; $display("FAIL timeout_start_len: got %0d want 15", len_n[b]); end
    tick(); tick();
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL timeout_err_sticky: got %b want 1", ERR); end
    pp_model_en = 1'b1;
    start_run(16'd1, 32'd2, 1'b1);
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL timeout_err_clear: got %b want 0", ERR); end
    wait_done("after_timeout");
    checks++; if (SCAN_IDX !== 16'd1 || ERR !== 1'b0) begin failures++; $display("FAIL after_timeout_run: idx=%0d err=%b want 1,0", SCAN_IDX, ERR); end
    tick();
  endtask

  task automatic test_abort();
    int b, k;
    b = n_starts;
    start_run(16'd5, 32'd4, 1'b1);
    k = 0;
    while (n_starts < b + 2 && k < 500) begin tick(); k++; end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    wait_done("abort_scan");
    checks++; if (SCAN_IDX !== 16'd2) begin failures++; $display("FAIL abort_scan_idx: got %0d want 2", SCAN_IDX); end
    checks++; if (n_starts - b !== 2) begin failures++; $display("FAIL abort_start_count: got %0d want 2", n_starts - b); end
    checks++; if (len_n[b+1] !== 3) begin failures++; $display("FAIL abort_scan_len: got %0d want 3", len_n[b+1]); end
    tick();
    b = n_starts;
    start_run(16'd5, 32'd20, 1'b1);
    k = 0;
    while (SCAN_IDX !== 16'd1 && k < 500) begin tick(); k++; end
    checks++; if (PHASE_CYC !== 1'b0) begin failures++; $display("FAIL abort_rep_phase: got %b want 0", PHASE_CYC); end
    tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL abort_rep_early_done: got %b want 0", DONE); end
    tick();
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL abort_rep_done: got %b want 1", DONE); end
    checks++; if (SCAN_IDX !== 16'd1 || n_starts - b !== 1) begin failures++; $display("FAIL abort_rep_state: idx=%0d starts=%0d want 1,1", SCAN_IDX, n_starts - b); end
    tick();
  endtask

  task automatic test_back_to_back();
    int b;
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    b = n_starts;
    start_run(16'd3, 32'd0, 1'b0);
    wait_done("b2b");
    checks++; if (SCAN_IDX !== 16'd3) begin failures++; $display("FAIL b2b_scan_idx: got %0d want 3", SCAN_IDX); end
    checks++; if (n_starts - b !== 3) begin failures++; $display("FAIL b2b_start_count: got %0d want 3", n_starts - b); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ph_n[b+i] !== 1'b1) begin failures++; $display("FAIL b2b_phase%0d: got %b want 1", i, ph_n[b+i]); end
      if (i > 0) begin
        checks++; if (gap_n[b+i] !== 1) begin failures++; $display("FAIL b2b_gap%0d: got %0d want 1", i, gap_n[b+i]); end
      end
    end
    checks++; if (PHASE_CYC !== 1'b1) begin failures++; $display("FAIL b2b_phase_end: got %b want 1", PHASE_CYC); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int b, k;
    b = n_starts;
    start_run(16'd3, 32'd2, 1'b1);
    k = 0;
    while (!(n_starts >= b + 2 && PP_FSMSTAT === 1'b1 && PP_START === 1'b0) && k < 500) begin tick(); k++; end
    checks++; if (BUSY !== 1'b1 || SCAN_IDX !== 16'd1 || PHASE_CYC !== 1'b0) begin failures++; $display("FAIL midrst_pre: busy=%b idx=%0d ph=%b want 1,1,0", BUSY, SCAN_IDX, PHASE_CYC); end
    RESET = 1'b1;
    #1;
    checks++; if (BUSY !== 1'b0 || SCAN_IDX !== 16'd0 || PHASE_CYC !== 1'b1 || PP_START !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL midrst_values: busy=%b idx=%0d ph=%b start=%b done=%b err=%b want 0,0,1,0,0,0", BUSY, SCAN_IDX, PHASE_CYC, PP_START, DONE, ERR);
    end
    tick();
    RESET = 1'b0;
    tick();
    b = n_starts;
    start_run(16'd2, 32'd3, 1'b1);
    wait_done("midrst_rerun");
    checks++; if (SCAN_IDX !== 16'd2 || n_starts - b !== 2 || ERR !== 1'b0) begin failures++; $display("FAIL midrst_rerun: idx=%0d starts=%0d err=%b want 2,2,0", SCAN_IDX, n_starts - b, ERR); end
    tick();
  endtask

  initial begin
    RESET        = 1'b1;
    RUN          = 1'b0;
    ABORT        = 1'b0;
    NUM_SCANS    = 16'd0;
    REP_DELAY    = 32'd0;
    PHASE_CYC_EN = 1'b0;
    pp_model_en  = 1'b1;
    test_reset();
    test_four_scans();
    test_zero_scans();
    test_ack_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
